actuated_signal_scheduler: RTL
==============================

Name: actuated_signal_scheduler

Overview:
- Sensor-actuated sequencer for the two-road intersection signal heads (green/yellow/red per road) with a pedestrian walk phase.
- Replaces fixed-time cycling: green is held while its road has traffic, and is released to the other road only on demand.
- Enforces minimum green, maximum green, yellow and all-red clearance times.
- Sits between the road vehicle sensors and pedestrian push-button and the lamp drivers.

Parameters:
- T_MIN_GREEN, 6: minimum green length in enabled cycles (>=1)
- T_MAX_GREEN, 12: green length after which gap extension is ignored if the other side demands (>=T_MIN_GREEN)
- T_EXT, 2: consecutive no-vehicle cycles that count as a gap (>=1)
- T_YELLOW, 3: yellow length in enabled cycles (>=1)
- T_ALL_RED, 1: all-red clearance length in enabled cycles (>=1)
- T_WALK, 4: pedestrian walk length in enabled cycles (>=1)
- CW, 5: timer width; must hold T_MAX_GREEN

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = advance timers and FSM; 0 = freeze all state, outputs hold
- sense_1  in  1  vehicle present on road 1 (level)
- sense_2  in  1  vehicle present on road 2 (level)
- ped_req  in  1  pedestrian button (pulse or level)
- green_1, yellow_1, red_1  out  1 each  road 1 lamps, exactly one high
- green_2, yellow_2, red_2  out  1 each  road 2 lamps, exactly one high
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state code (debug/status)

Behaviour:
- States and codes: G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5, PED=6.
- Outputs are decoded from the state register only; there is no combinational input-to-output path.
  - G1: green_1=1, red_2=1.
  - Y1: yellow_1=1, red_2=1.
  - G2: red_1=1, green_2=1.
  - Y2: red_1=1, yellow_2=1.
  - AR1, AR2, PED: red_1=red_2=1.
  - walk=1 only in PED.
- Reset (sampled on clk edge, overrides enable):
  - state=AR2, timer=0, gap=0, ped_pending=0, next_road=1.
  - Outputs: red_1=red_2=1, all others 0, walk=0, phase=5.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments each enabled cycle, saturating at T_MAX_GREEN-1.
  - A timed state of length N exits on the enabled cycle where timer==N-1, so the state is visible for exactly N enabled cycles.
- Gap counter (green states only):
  - Counts consecutive enabled cycles in which the active road's sensor is 0, saturating at T_EXT.
  - Cleared when that sensor is 1 and on entry to green.
  - gap_ok = (gap == T_EXT).
- Demand:
  - Demand in G1 = sense_2 | ped_pending.
  - Demand in G2 = sense_1 | ped_pending.
- Gx exit (to Yx): demand & timer >= T_MIN_GREEN-1 & (gap_ok | timer == T_MAX_GREEN-1).
  - Without demand, green rests indefinitely; the timer stays saturated.
- Yx exits to ARx after T_YELLOW cycles.
- ARx lasts T_ALL_RED cycles, then:
  - If ped_pending: go to PED and record next_road = other road.
  - Otherwise: AR1 goes to G2, AR2 goes to G1.
- PED lasts T_WALK cycles, then goes to G1 if next_road==0, else G2.
- ped_pending:
  - Set by ped_req on any enabled cycle.
  - Cleared on the transition into PED; clear wins over a simultaneous ped_req.
  - A ped_req during PED sets it again, so a new pedestrian phase follows after the next green.
- After reset: AR2 for T_ALL_RED cycles, then G1. A ped_req held through reset is ignored.
- enable=0 in mid-state: timer, gap, ped_pending and state all hold. ped_req is not captured while disabled.
- reset asserted in any state, including PED mid-walk: next edge forces the reset values.
- Never both roads non-red; every green is followed by yellow and then all-red.

Test Plan:
- Reset 3 cycles, release with sense_1=sense_2=ped_req=0 -> phase=5, red_1=red_2=1 for 1 cycle, then G1 (green_1=1, red_2=1) held for 50 cycles.
- In G1, sense_1=0, raise sense_2 at G1 cycle 2 -> green_1 for 6 cycles total, yellow_1 for 3, all-red 1, then green_2.
- In G1, sense_1 held 1, sense_2=1 -> green_1 lasts exactly 12 cycles (max green), then yellow_1.
- In G2, pulse ped_req, sense_1=0 -> after min green: Y2 3, AR2 1, PED 4 with walk=1 and both red, then G1; ped_pending cleared.
- Drop enable for 10 cycles mid-Y1 -> yellow_1 held; Y1 total remains 3 enabled cycles after enable returns.
- Assert reset during PED -> next edge phase=5, walk=0, ped_pending=0.
- All runs: assert every cycle that exactly one lamp per road is on and that green_1 & ~red_2 never coincides with ~red_1.

Source files
------------

// File: rtl/actuated_signal_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : actuated_signal_scheduler
// Description : Two-road actuated traffic signal sequencer with gap extension,
//               min/max green, yellow, all-red clearance and pedestrian walk.
// Revision    : 1.0 - initial release
// ============================================================================
module actuated_signal_scheduler #(
    parameter int T_MIN_GREEN = 6,
    parameter int T_MAX_GREEN = 12,
    parameter int T_EXT       = 2,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int T_WALK      = 4,
    parameter int CW          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sense_1,
    input  logic       sense_2,
    input  logic       ped_req,
    output logic       green_1,
    output logic       yellow_1,
    output logic       red_1,
    output logic       green_2,
    output logic       yellow_2,
    output logic       red_2,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [2:0] S_G1  = 3'd0;
    localparam logic [2:0] S_Y1  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_G2  = 3'd3;
    localparam logic [2:0] S_Y2  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;
    localparam logic [2:0] S_PED = 3'd6;

    localparam logic [CW-1:0] C_MIN_LAST  = CW'(T_MIN_GREEN - 1);
    localparam logic [CW-1:0] C_MAX_LAST  = CW'(T_MAX_GREEN - 1);
    localparam logic [CW-1:0] C_EXT       = CW'(T_EXT);
    localparam logic [CW-1:0] C_Y_LAST    = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] C_AR_LAST   = CW'(T_ALL_RED - 1);
    localparam logic [CW-1:0] C_WALK_LAST = CW'(T_WALK - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [CW-1:0] gap_q, gap_d;
    logic          ped_pending_q, ped_pending_d;
    logic          next_road_q, next_road_d;

    logic w_in_green;
    logic w_active_sense;
    logic w_other_sense;
    logic w_demand;
    logic w_gap_ok;

    always_comb begin
        w_in_green     = (state_q == S_G1) || (state_q == S_G2);
        w_active_sense = (state_q == S_G2) ? sense_2 : sense_1;
        w_other_sense  = (state_q == S_G2) ? sense_1 : sense_2;
        w_demand       = w_other_sense | ped_pending_q;
        w_gap_ok       = (gap_q == C_EXT);
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        gap_d         = gap_q;
        ped_pending_d = ped_pending_q;
        next_road_d   = next_road_q;

        if (enable) begin
            case (state_q)
                S_G1, S_G2: begin
                    if (w_demand && (timer_q >= C_MIN_LAST) &&
                        (w_gap_ok || (timer_q == C_MAX_LAST))) begin
                        state_d = (state_q == S_G1) ? S_Y1 : S_Y2;
                    end
                end
                S_Y1: if (timer_q == C_Y_LAST) state_d = S_AR1;
                S_Y2: if (timer_q == C_Y_LAST) state_d = S_AR2;
                S_AR1, S_AR2: begin
                    if (timer_q == C_AR_LAST) begin
                        if (ped_pending_q) begin
                            state_d     = S_PED;
                            // Serve the road that did not just have green.
                            next_road_d = (state_q == S_AR1);
                        end else begin
                            state_d = (state_q == S_AR1) ? S_G2 : S_G1;
                        end
                    end
                end
                S_PED: if (timer_q == C_WALK_LAST) state_d = next_road_q ? S_G2 : S_G1;
                default: state_d = S_AR2;
            endcase

            if (state_d != state_q) begin
                timer_d = '0;
            end else if (timer_q != C_MAX_LAST) begin
                timer_d = timer_q + 1'b1;
            end

            if ((state_d != state_q) || !w_in_green || w_active_sense) begin
                gap_d = '0;
            end else if (gap_q != C_EXT) begin
                gap_d = gap_q + 1'b1;
            end

            // Entering the walk phase consumes the request, even one arriving now.
            if ((state_d == S_PED) && (state_q != S_PED)) begin
                ped_pending_d = 1'b0;
            end else if (ped_req) begin
                ped_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_AR2;
            timer_q       <= '0;
            gap_q         <= '0;
            ped_pending_q <= 1'b0;
            next_road_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            ped_pending_q <= ped_pending_d;
            next_road_q   <= next_road_d;
        end
    end

    always_comb begin
        green_1  = (state_q == S_G1);
        yellow_1 = (state_q == S_Y1);
        red_1    = !((state_q == S_G1) || (state_q == S_Y1));
        green_2  = (state_q == S_G2);
        yellow_2 = (state_q == S_Y2);
        red_2    = !((state_q == S_G2) || (state_q == S_Y2));
        walk     = (state_q == S_PED);
        phase    = state_q;
    end

endmodule
`default_nettype wire
